// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the multi-cycle MIPS pipeline. Sits between the
// EX/MEM register and the WB control register. Non-memory instructions pass
// their ALU result straight to WB with one cycle of latency. Word loads and
// stores run against a handshaked data memory. A two-state FSM (IDLE/BUSY)
// drives the bus and stalls upstream while an access is in flight.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access that sees
// no dmem_ack for TIMEOUT cycles. The abort pulses bus_err. Without the
// macro, BUSY waits indefinitely and bus_err is tied low.
//
// Parameters
//   DATA_W   data / address width
//   TIMEOUT  BUSY cycles without ack before abort (MEM_TIMEOUT_EN only)
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   flush             squash the current and pending write-back
//   valid_in          EX/MEM holds a valid instruction
//   mem_read_in       load word
//   mem_write_in      store word
//   mem_to_reg_in     write-back control
//   wr_reg_in         write-back control
//   alu_result_in     ALU result / effective address
//   store_data_in     store data
//   wr_addr_in        destination register
//   stall_out         upstream must hold EX/MEM (high in every BUSY cycle)
//   dmem_req          memory request, registered
//   dmem_we           memory write enable, registered
//   dmem_addr         memory address, registered
//   dmem_wdata        memory write data, registered
//   dmem_rdata        memory read data (valid with dmem_ack)
//   dmem_ack          access complete
//   valid_out         to WB stage
//   mem_to_reg_out    to WB stage
//   wr_reg_out        to WB stage
//   read_data_out     to WB mux
//   alu_result_out    to WB mux
//   wr_addr_out       to WB stage
//   misalign_err      one-cycle error pulse
//   bus_err           one-cycle error pulse
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_to_reg_in,
    input  logic              wr_reg_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [4:0]        wr_addr_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              valid_out,
    output logic              mem_to_reg_out,
    output logic              wr_reg_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [4:0]        wr_addr_out,
    output logic              misalign_err,
    output logic              bus_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_next;

    // Decoded actions for the current cycle
    logic mem_op;
    logic aligned;
    logic do_pass;
    logic do_start;
    logic do_misalign;
    logic do_complete;
    logic do_abort;
    logic timeout_hit;

    // Instruction captured at the start of an access
    logic              cap_read;
    logic              cap_mem_to_reg;
    logic              cap_wr_reg;
    logic [DATA_W-1:0] cap_alu_result;
    logic [4:0]        cap_wr_addr;

    // Set by a flush seen while BUSY; kills the write-back on completion
    logic squash;
    logic squash_eff;

    assign stall_out  = (state == BUSY);
    assign squash_eff = squash | flush;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM next state / action decode ----------------
    always_comb begin
        state_next  = state;
        mem_op      = mem_read_in | mem_write_in;
        aligned     = (alu_result_in[1:0] == 2'b00);
        do_pass     = 1'b0;
        do_start    = 1'b0;
        do_misalign = 1'b0;
        do_complete = 1'b0;
        do_abort    = 1'b0;

        case (state)
            IDLE: begin
                // A flush in IDLE turns this cycle into a bubble.
                if (valid_in && !flush) begin
                    if (!mem_op) begin
                        do_pass = 1'b1;
                    end else if (aligned) begin
                        do_start   = 1'b1;
                        state_next = BUSY;
                    end else begin
                        do_misalign = 1'b1;
                    end
                end
            end
            BUSY: begin
                // An ack arriving in the timeout cycle takes priority.
                if (dmem_ack) begin
                    do_complete = 1'b1;
                    state_next  = IDLE;
                end else if (timeout_hit) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- Capture registers (data only, no reset) ----------------
    always_ff @(posedge clk) begin
        if (do_start) begin
            cap_read       <= mem_read_in;
            cap_mem_to_reg <= mem_to_reg_in;
            cap_wr_reg     <= wr_reg_in;
            cap_alu_result <= alu_result_in;
            cap_wr_addr    <= wr_addr_in;
        end
    end

    // ---------------- Bus and write-back output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            valid_out      <= 1'b0;
            mem_to_reg_out <= 1'b0;
            wr_reg_out     <= 1'b0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            wr_addr_out    <= '0;
            misalign_err   <= 1'b0;
            squash         <= 1'b0;
        end else begin
            // Default: bubble to WB, no error pulse.
            valid_out      <= 1'b0;
            mem_to_reg_out <= 1'b0;
            wr_reg_out     <= 1'b0;
            misalign_err   <= 1'b0;

            if (do_pass) begin
                valid_out      <= 1'b1;
                mem_to_reg_out <= mem_to_reg_in;
                wr_reg_out     <= wr_reg_in;
                alu_result_out <= alu_result_in;
                wr_addr_out    <= wr_addr_in;
            end

            // Misaligned access: no bus cycle, retire with no register write.
            if (do_misalign) begin
                valid_out      <= 1'b1;
                misalign_err   <= 1'b1;
                alu_result_out <= alu_result_in;
                wr_addr_out    <= wr_addr_in;
            end

            if (do_start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write_in;
                dmem_addr  <= alu_result_in;
                dmem_wdata <= store_data_in;
                squash     <= 1'b0;
            end

            // The bus access is never cut short by flush; only WB is killed.
            if (state == BUSY && flush) begin
                squash <= 1'b1;
            end

            if (do_complete) begin
                dmem_req       <= 1'b0;
                dmem_we        <= 1'b0;
                valid_out      <= !squash_eff;
                mem_to_reg_out <= cap_mem_to_reg & !squash_eff;
                wr_reg_out     <= cap_wr_reg & !squash_eff;
                alu_result_out <= cap_alu_result;
                wr_addr_out    <= cap_wr_addr;
                if (cap_read) begin
                    read_data_out <= dmem_rdata;
                end
                squash <= 1'b0;
            end

            if (do_abort) begin
                dmem_req       <= 1'b0;
                dmem_we        <= 1'b0;
                valid_out      <= !squash_eff;
                alu_result_out <= cap_alu_result;
                wr_addr_out    <= cap_wr_addr;
                squash         <= 1'b0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] busy_cnt;

    // Counts BUSY cycles without ack; hitting TIMEOUT-1 here means this is
    // the TIMEOUT-th such cycle, so the abort lands on this edge.
    assign timeout_hit = (state == BUSY) && (busy_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= do_abort;
            if (do_start) begin
                busy_cnt <= '0;
            end else if (state == BUSY && !dmem_ack) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

endmodule
